// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE S-box lanes per clock.
// Optional macro INV_SUB_BYTES_FWD_EN adds fwd_mode to select the forward S-box per operation.
module inv_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic         fwd_mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  localparam int BPC  = BYTES_PER_CYCLE;
  localparam int NGRP = 16 / BPC;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(NGRP - 1);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_check
    $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef INV_SUB_BYTES_FWD_EN
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic fwd_q, fwd_d;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [7:0]    work_q [16];
  logic [7:0]    work_d [16];
  logic [7:0]    lane_in  [BPC];
  logic [7:0]    lane_out [BPC];
  logic [3:0]    base;

  // First byte of the group currently being substituted; wraps to 0 harmlessly when BPC=16.
  assign base = 4'(32'(grp_q) * BPC);

  for (genvar gi = 0; gi < BPC; gi++) begin : g_lane
    assign lane_in[gi] = work_q[base + 4'(gi)];
`ifdef INV_SUB_BYTES_FWD_EN
    assign lane_out[gi] = fwd_q ? SBOX[lane_in[gi]] : INV_SBOX[lane_in[gi]];
`else
    assign lane_out[gi] = INV_SBOX[lane_in[gi]];
`endif
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    work_d  = work_q;
`ifdef INV_SUB_BYTES_FWD_EN
    fwd_d   = fwd_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < 16; k++) work_d[k] = in_state[8*k +: 8];
          grp_d   = '0;
`ifdef INV_SUB_BYTES_FWD_EN
          fwd_d   = fwd_mode;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < BPC; l++) work_d[base + 4'(l)] = lane_out[l];
        grp_d = grp_q + 1'b1;
        if (grp_q == LAST_GRP) begin
          grp_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      for (int k = 0; k < 16; k++) work_q[k] <= 8'h00;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      work_q  <= work_d;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q   <= fwd_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  for (genvar gi = 0; gi < 16; gi++) begin : g_out
    assign out_state[8*gi +: 8] = out_valid ? work_q[gi] : 8'h00;
  end

endmodule
